// File: rtl/control_pkg.sv
// Shared definitions for the PI control loop: FSM state encodings and
// signed saturation / clamping helpers.
package control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic signed [32:0] SAT33_HI = 33'sh0_7FFF_FFFF;
    localparam logic signed [32:0] SAT33_LO = 33'sh1_8000_0000;

    // Squeeze a 33-bit signed value into the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
        logic signed [31:0] r;
        if (v > SAT33_HI) begin
            r = 32'sh7FFF_FFFF;
        end else if (v < SAT33_LO) begin
            r = 32'sh8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    function automatic logic signed [31:0] clamp32(
        input logic signed [31:0] v,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        logic signed [31:0] r;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// Combinational step limiter: moves cur toward tgt by at most step.
// at_tgt flags that the full remaining distance fits in one step.
module slew_limiter (
    input  logic signed [31:0] cur,
    input  logic signed [31:0] tgt,
    input  logic [31:0]        step,
    output logic signed [31:0] next,
    output logic               at_tgt
);

    logic signed [32:0] diff;
    logic [32:0]        mag;
    logic [31:0]        lim;

    always_comb begin
        diff   = {tgt[31], tgt} - {cur[31], cur};
        mag    = diff[32] ? $unsigned(-diff) : $unsigned(diff);
        at_tgt = (mag <= {1'b0, step});
        // When at_tgt, mag <= step so its top bit is necessarily zero.
        lim    = at_tgt ? mag[31:0] : step;
        // The true result lies between cur and tgt, so 32-bit wrap arithmetic is exact.
        next   = diff[32] ? (cur - $signed(lim)) : (cur + $signed(lim));
    end

endmodule

// File: rtl/pi_output_conditioner.sv
// Converts raw PI output into the modulator command: soft-start ramp, clamp,
// per-sample slew limit, anti-windup feedback and enable/fault sequencing.
module pi_output_conditioner
    import control_pkg::*;
#(
    parameter logic signed [31:0] CMD_MIN   = -32'sd1000,
    parameter logic signed [31:0] CMD_MAX   = 32'sd1000,
    parameter logic signed [31:0] CMD_INIT  = 32'sd0,
    parameter logic signed [31:0] CMD_SAFE  = 32'sd0,
    parameter logic signed [31:0] RAMP_STEP = 32'sd4,
    parameter logic signed [31:0] SLEW_MAX  = 32'sd64
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_STROBE,
    input  logic        i_EN,
    input  logic        i_FAULT,
    input  logic [31:0] i_PI,
    output logic [31:0] o_CMD,
    output logic [31:0] o_AW,
    output logic        o_VALID,
    output logic        o_SAT,
    output logic [1:0]  o_STATE
);

    state_t             state_reg, state_next;
    logic signed [31:0] cmd_reg, cmd_next;
    logic signed [31:0] aw_reg, aw_next;
    logic               valid_reg, valid_next;
    logic               sat_reg, sat_next;

    logic signed [31:0] pi_s;
    logic signed [31:0] tgt;
    logic [31:0]        step_sel;
    logic signed [31:0] slew_next;
    logic               slew_at_tgt;

    assign pi_s     = $signed(i_PI);
    assign tgt      = clamp32(pi_s, CMD_MIN, CMD_MAX);
    assign step_sel = (state_reg == ST_RUN) ? $unsigned(SLEW_MAX) : $unsigned(RAMP_STEP);

    slew_limiter u_slew (
        .cur    (cmd_reg),
        .tgt    (tgt),
        .step   (step_sel),
        .next   (slew_next),
        .at_tgt (slew_at_tgt)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_reg <= ST_IDLE;
            cmd_reg   <= CMD_INIT;
            aw_reg    <= '0;
            valid_reg <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            aw_reg    <= aw_next;
            valid_reg <= valid_next;
            sat_reg   <= sat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        aw_next    = aw_reg;
        valid_next = 1'b0;
        sat_next   = sat_reg;

        if (i_FAULT) begin
            state_next = ST_FAULT;
            cmd_next   = CMD_SAFE;
            aw_next    = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cmd_next = CMD_INIT;
                    aw_next  = '0;
                    sat_next = 1'b0;
                    if (i_EN) begin
                        state_next = ST_RAMP;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (!i_EN) begin
                        state_next = ST_IDLE;
                        cmd_next   = CMD_INIT;
                        aw_next    = '0;
                        sat_next   = 1'b0;
                    end else if (i_STROBE) begin
                        cmd_next   = slew_next;
                        // Anti-windup sees clamp excess only; slew limiting is invisible to it.
                        aw_next    = sat32({tgt[31], tgt} - {pi_s[31], pi_s});
                        sat_next   = (pi_s > CMD_MAX) || (pi_s < CMD_MIN);
                        valid_next = 1'b1;
                        if ((state_reg == ST_RAMP) && slew_at_tgt) begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_FAULT: begin
                    cmd_next = CMD_SAFE;
                    aw_next  = '0;
                    sat_next = 1'b0;
                    // Leaving a fault requires the enable to drop too, so the loop re-ramps.
                    if (!i_EN) begin
                        state_next = ST_IDLE;
                        cmd_next   = CMD_INIT;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cmd_next   = CMD_INIT;
                end
            endcase
        end
    end

    assign o_CMD   = cmd_reg;
    assign o_AW    = aw_reg;
    assign o_VALID = valid_reg;
    assign o_SAT   = sat_reg;
    assign o_STATE = state_reg;

endmodule

// File: tb/tb_pi_output_conditioner.sv
// Directed-vector bench for pi_output_conditioner; a second instance with
// CMD_MIN=0 exercises saturation of the anti-windup difference.
module tb_pi_output_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic        en;
    logic        fault;
    logic [31:0] pi;

    logic [31:0] cmd, aw, cmd2, aw2;
    logic        valid, sat, valid2, sat2;
    logic [1:0]  state, state2;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;

    always #5 clk = ~clk;

    pi_output_conditioner dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_STROBE (strobe),
        .i_EN     (en),
        .i_FAULT  (fault),
        .i_PI     (pi),
        .o_CMD    (cmd),
        .o_AW     (aw),
        .o_VALID  (valid),
        .o_SAT    (sat),
        .o_STATE  (state)
    );

    pi_output_conditioner #(
        .CMD_MIN (32'sd0)
    ) dut_sat (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_STROBE (strobe),
        .i_EN     (en),
        .i_FAULT  (fault),
        .i_PI     (pi),
        .o_CMD    (cmd2),
        .o_AW     (aw2),
        .o_VALID  (valid2),
        .o_SAT    (sat2),
        .o_STATE  (state2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) vcnt++;
    endtask

    task automatic pulse();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    int slew_exp [5] = '{64, 128, 192, 256, 300};

    initial begin
        rst = 1'b1; en = 1'b1; fault = 1'b0; strobe = 1'b0; pi = 32'd0;

        // Reset
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cmd",   cmd,   32'd0);
        chk("rst_aw",    aw,    32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sat",   32'(sat),   32'd0);

        // Soft-start toward 20 in steps of 4
        rst = 1'b0; pi = 32'd20;
        tick();
        chk("ramp_enter", 32'(state), 32'd1);
        vcnt = 0;
        for (int i = 1; i <= 5; i++) begin
            pulse();
            chk("ramp_cmd",   cmd, 32'(4 * i));
            chk("ramp_valid", 32'(valid), 32'd1);
            chk("ramp_state", 32'(state), (i == 5) ? 32'd2 : 32'd1);
            tick();
            chk("ramp_hold",  cmd, 32'(4 * i));
            chk("ramp_vdrop", 32'(valid), 32'd0);
        end
        chk("ramp_vcount", 32'(vcnt), 32'd5);

        // Slew-limited approach from 0 to 300
        pi = 32'd0;
        pulse();
        chk("slew_zero", cmd, 32'd0);
        pi = 32'd300;
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk("slew_cmd", cmd, 32'(slew_exp[i]));
            chk("slew_aw",  aw,  32'd0);
        end

        // Clamp and anti-windup
        pi = 32'd1500;
        repeat (12) pulse();
        chk("clamp_cmd", cmd, 32'd1000);
        chk("clamp_aw",  aw,  32'hFFFF_FE0C);
        chk("clamp_sat", 32'(sat), 32'd1);
        pi = -32'sd1200;
        pulse();
        chk("neg_cmd", cmd, 32'd936);
        chk("neg_aw",  aw,  32'd200);
        chk("neg_sat", 32'(sat), 32'd1);
        pi = 32'd500;
        pulse();
        chk("in_cmd", cmd, 32'd872);
        chk("in_aw",  aw,  32'd0);
        chk("in_sat", 32'(sat), 32'd0);

        // Extreme inputs
        pi = 32'h8000_0000;
        pulse();
        chk("xmin_cmd", cmd, 32'd808);
        chk("xmin_aw",  aw,  32'h7FFF_FC18);
        chk("xmin_aw_sat", aw2, 32'h7FFF_FFFF);
        pi = 32'h7FFF_FFFF;
        pulse();
        chk("xmax_cmd", cmd, 32'd872);
        chk("xmax_aw",  aw,  32'h8000_03E9);

        // Fault wins over a same-cycle strobe
        fault = 1'b1; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("flt_state", 32'(state), 32'd3);
        chk("flt_cmd",   cmd, 32'd0);
        chk("flt_aw",    aw,  32'd0);
        chk("flt_valid", 32'(valid), 32'd0);
        fault = 1'b0;
        tick();
        chk("flt_hold_en", 32'(state), 32'd3);
        en = 1'b0;
        tick();
        chk("flt_exit", 32'(state), 32'd0);
        chk("flt_exit_cmd", cmd, 32'd0);

        // Disable mid-ramp, with a strobe pending in the same cycle
        en = 1'b1; pi = 32'd20;
        tick();
        pulse(); pulse();
        chk("dis_pre", cmd, 32'd8);
        en = 1'b0; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_cmd",   cmd, 32'd0);
        chk("dis_valid", 32'(valid), 32'd0);

        // Reset mid-ramp, then restart from CMD_INIT
        en = 1'b1;
        tick();
        pulse(); pulse();
        chk("mrst_pre", cmd, 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_cmd",   cmd, 32'd0);
        tick();
        pulse();
        chk("restart_cmd", cmd, 32'd4);
        chk("restart_state", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
